// File: rtl/stereo_frame_streamer.sv
// Frame-memory reader: streams a stored left/right frame pair in raster order
// with a programmable idle gap after each row, tagging pixels with (x, y).
module stereo_frame_streamer #(
  parameter int unsigned row_sz   = 320,
  parameter int unsigned col_sz   = 480,
  parameter int unsigned LINE_GAP = 4,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [17:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_wait,
  input  logic [7:0]  mem_left,
  input  logic [7:0]  mem_right,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y,
  output logic [7:0]  out_left,
  output logic [7:0]  out_right,
  output logic        out_is_val,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DRAIN} state_t;

  localparam int unsigned GW       = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [9:0]  X_LAST   = 10'(row_sz - 1);
  localparam logic [9:0]  Y_LAST   = 10'(col_sz - 1);

  state_t              state, state_next;
  logic [9:0]          x, y;
  logic [GW-1:0]       gap_cnt;
  logic                accept;
  logic                clear_cnt;
  logic [RD_LAT-1:0]   tag_vld;
  logic [9:0]          tag_x [RD_LAT];
  logic [9:0]          tag_y [RD_LAT];

  assign accept = mem_rd & ~mem_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic uses mem_wait directly so mem_rd never feeds back into itself.
  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    clear_cnt  = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          clear_cnt  = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        mem_rd = 1'b1;
        if (!mem_wait && x == X_LAST) begin
          if (y == Y_LAST) begin
            state_next = DRAIN;
          end else if (LINE_GAP > 0) begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = ACTIVE;
        end
      end
      DRAIN: begin
        // Last pixel is on the output registers in the cycle the pipeline empties.
        if (tag_vld == '0) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      mem_addr   <= '0;
      gap_cnt    <= '0;
      tag_vld    <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_is_val <= 1'b0;
    end else begin
      if (clear_cnt) begin
        x        <= '0;
        y        <= '0;
        mem_addr <= '0;
      end else if (accept) begin
        mem_addr <= mem_addr + 18'd1;
        if (x == X_LAST) begin
          x <= '0;
          if (y != Y_LAST) begin
            y <= y + 10'd1;
          end
        end else begin
          x <= x + 10'd1;
        end
      end

      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;

      tag_vld[0] <= accept;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
      end

      out_is_val <= tag_vld[RD_LAT-1];
      if (tag_vld[RD_LAT-1]) begin
        out_x     <= tag_x[RD_LAT-1];
        out_y     <= tag_y[RD_LAT-1];
        out_left  <= mem_left;
        out_right <= mem_right;
      end
    end
  end

  // Tag payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    tag_x[0] <= x;
    tag_y[0] <= y;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_x[i] <= tag_x[i-1];
      tag_y[i] <= tag_y[i-1];
    end
  end

endmodule

// File: tb/tb_stereo_frame_streamer.sv
// Directed bench: two streamers (row gap 2 and row gap 0) on 4x3 frames,
// each fed by a latency-2 memory returning left=addr, right=addr+100.
module tb_stereo_frame_streamer;

  localparam int RS = 4;
  localparam int CS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, mem_wait, sel;

  logic [17:0] m_addr  [2];
  logic        m_rd    [2];
  logic        m_wait  [2];
  logic        m_start [2];
  logic [7:0]  m_left  [2];
  logic [7:0]  m_right [2];
  logic [9:0]  o_x     [2];
  logic [9:0]  o_y     [2];
  logic [7:0]  o_l     [2];
  logic [7:0]  o_r     [2];
  logic        o_val   [2];
  logic        o_busy  [2];
  logic        o_done  [2];

  int nvec = 0;
  int nerr = 0;

  stereo_frame_streamer #(.row_sz(RS), .col_sz(CS), .LINE_GAP(2), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(m_start[0]),
    .mem_addr(m_addr[0]), .mem_rd(m_rd[0]), .mem_wait(m_wait[0]),
    .mem_left(m_left[0]), .mem_right(m_right[0]),
    .out_x(o_x[0]), .out_y(o_y[0]), .out_left(o_l[0]), .out_right(o_r[0]),
    .out_is_val(o_val[0]), .busy(o_busy[0]), .frame_done(o_done[0])
  );

  stereo_frame_streamer #(.row_sz(RS), .col_sz(CS), .LINE_GAP(0), .RD_LAT(2)) dut_nogap (
    .clk(clk), .reset(reset), .start(m_start[1]),
    .mem_addr(m_addr[1]), .mem_rd(m_rd[1]), .mem_wait(m_wait[1]),
    .mem_left(m_left[1]), .mem_right(m_right[1]),
    .out_x(o_x[1]), .out_y(o_y[1]), .out_left(o_l[1]), .out_right(o_r[1]),
    .out_is_val(o_val[1]), .busy(o_busy[1]), .frame_done(o_done[1])
  );

  // Memory model: data for a read accepted at edge k is valid in cycle k+2.
  logic        mv1 [2];
  logic        mv2 [2];
  logic [17:0] ma1 [2];
  logic [17:0] ma2 [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mv1[d] <= m_rd[d] && !m_wait[d];
      ma1[d] <= m_addr[d];
      mv2[d] <= mv1[d];
      ma2[d] <= ma1[d];
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      m_start[d] = start && (sel == 1'(d));
      m_wait[d]  = mem_wait && (sel == 1'(d));
      m_left[d]  = mv2[d] ? ma2[d][7:0] : 8'hEE;
      m_right[d] = mv2[d] ? ma2[d][7:0] + 8'd100 : 8'hEE;
    end
  end

  logic [17:0] v_addr;
  logic        v_rd, v_val, v_busy, v_done;
  logic [9:0]  v_x, v_y;
  logic [7:0]  v_l, v_r;

  assign v_addr = m_addr[sel];
  assign v_rd   = m_rd[sel];
  assign v_x    = o_x[sel];
  assign v_y    = o_y[sel];
  assign v_l    = o_l[sel];
  assign v_r    = o_r[sel];
  assign v_val  = o_val[sel];
  assign v_busy = o_busy[sel];
  assign v_done = o_done[sel];

  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, " out_x"}, v_x, 0);
    check({nm, " out_y"}, v_y, 0);
    check({nm, " out_left"}, v_l, 0);
    check({nm, " out_right"}, v_r, 0);
    check({nm, " out_is_val"}, v_val, 0);
    check({nm, " busy"}, v_busy, 0);
    check({nm, " frame_done"}, v_done, 0);
    check({nm, " mem_rd"}, v_rd, 0);
    check({nm, " mem_addr"}, v_addr, 0);
  endtask

  // Called at a negedge: pulses start and follows one frame to the cycle after frame_done.
  task automatic run_frame(input string nm, input int exp_gap, input int stall_addr,
                           input int dup_px, input int reset_after, input int exp_len);
    int idx = 0;
    int cyc = 0;
    int done_cyc = -1;
    int last_val = 0;
    int last_acc = 0;
    int accepts = 0;
    int stalls = 0;
    bit finished = 1'b0;
    start = 1'b1;
    while (!finished && cyc < 120) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        check({nm, " first mem_rd"}, v_rd, 1);
        check({nm, " first mem_addr"}, v_addr, 0);
        check({nm, " busy cycle1"}, v_busy, 1);
      end
      if (v_val) begin
        if (exp_gap >= 0 && idx > 0)
          check({nm, " idle gap"}, cyc - last_val - 1, (idx % RS == 0) ? exp_gap : 0);
        check({nm, " out_x"}, v_x, idx % RS);
        check({nm, " out_y"}, v_y, idx / RS);
        check({nm, " out_left"}, v_l, idx);
        check({nm, " out_right"}, v_r, idx + 100);
        if (idx == dup_px) start = 1'b1;
        last_val = cyc;
        idx++;
      end
      if (done_cyc >= 0) begin
        check({nm, " val after done"}, v_val, 0);
        check({nm, " done pulse width"}, v_done, 0);
        check({nm, " busy after done"}, v_busy, 0);
        finished = 1'b1;
      end else if (v_done) begin
        done_cyc = cyc;
        check({nm, " busy at done"}, v_busy, 1);
        check({nm, " done after last read"}, cyc - last_acc, 3);
        check({nm, " pixel count"}, idx, RS * CS);
        if (exp_len > 0) check({nm, " frame length"}, cyc, exp_len);
      end
      if (!finished && reset_after > 0 && accepts == reset_after) begin
        reset = 1'b1;
        @(negedge clk);
        check_zero({nm, " after reset"});
        reset = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check({nm, " no val after reset"}, v_val, 0);
        end
        finished = 1'b1;
      end else if (!finished) begin
        if (stall_addr >= 0) begin
          if (stalls == 0 && v_rd && v_addr == 18'(stall_addr)) begin
            stalls = 1;
            mem_wait = 1'b1;
          end else if (stalls >= 1 && stalls <= 3) begin
            check({nm, " stall addr hold"}, v_addr, stall_addr);
            check({nm, " stall mem_rd"}, v_rd, 1);
            mem_wait = (stalls < 3);
            stalls++;
          end
        end
        if (v_rd && !mem_wait) begin
          accepts++;
          last_acc = cyc;
        end
      end
    end
    if (!finished) check({nm, " timeout"}, 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mem_wait = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset gap2");
    sel = 1'b1;
    #1;
    check_zero("reset gap0");
    sel = 1'b0;
    #1;
    reset = 1'b0;
    @(negedge clk);

    run_frame("plain", 2, -1, -1, -1, 19);
    repeat (2) @(negedge clk);
    run_frame("stall", -1, 5, -1, -1, 22);
    repeat (2) @(negedge clk);
    run_frame("start busy", 2, -1, 6, -1, 19);
    repeat (2) @(negedge clk);
    run_frame("reset mid", 2, -1, -1, 7, -1);
    run_frame("after reset", 2, -1, -1, -1, 19);
    repeat (2) @(negedge clk);
    run_frame("b2b first", 2, -1, -1, -1, 19);
    run_frame("b2b second", 2, -1, -1, -1, 19);

    sel = 1'b1;
    @(negedge clk);
    run_frame("gap0", 0, -1, -1, -1, 15);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
